// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with clamped preload, registered wrap pulse and sticky wrap flags.
// Latency 1 cycle; no backpressure. Define COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Value,
  input  logic             Clear_Flag,
  output logic [WIDTH-1:0] Counter_Out,
  output logic             Terminal,
  output logic             blow_up,
  output logic             underflow
);

  // MODULUS-1 always fits in WIDTH bits, even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

`ifdef COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_BOUND_NEXT = MAX_VAL;
  localparam logic [WIDTH-1:0] DN_BOUND_NEXT = ZERO_VAL;
`else
  localparam logic [WIDTH-1:0] UP_BOUND_NEXT = ZERO_VAL;
  localparam logic [WIDTH-1:0] DN_BOUND_NEXT = MAX_VAL;
`endif

  logic             at_max;
  logic             at_min;
  logic             step_up;
  logic             step_dn;
  logic             set_bu;
  logic             set_uf;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] cnt_nxt;

  assign at_max       = (Counter_Out == MAX_VAL);
  assign at_min       = (Counter_Out == ZERO_VAL);
  assign step_up      = !Load && En && Up;
  assign step_dn      = !Load && En && !Up;
  assign set_bu       = step_up && at_max;
  assign set_uf       = step_dn && at_min;
  assign load_clamped = (Load_Value > MAX_VAL) ? MAX_VAL : Load_Value;

  always_comb begin
    cnt_nxt = Counter_Out;
    if (Load) begin
      cnt_nxt = load_clamped;
    end else if (step_up) begin
      cnt_nxt = at_max ? UP_BOUND_NEXT : (Counter_Out + ONE_VAL);
    end else if (step_dn) begin
      cnt_nxt = at_min ? DN_BOUND_NEXT : (Counter_Out - ONE_VAL);
    end
  end

  // A set event in the same cycle as Clear_Flag keeps the flag high.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Counter_Out <= '0;
      Terminal    <= 1'b0;
      blow_up     <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      Counter_Out <= cnt_nxt;
      Terminal    <= set_bu || set_uf;
      blow_up     <= set_bu || (blow_up && !Clear_Flag);
      underflow   <= set_uf || (underflow && !Clear_Flag);
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed stimulus for mod_updown_counter (WIDTH=4, MODULUS=10),
// checked every cycle against a modular-arithmetic reference model.
module tb_mod_updown_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         En;
  logic         Up;
  logic         Load;
  logic [W-1:0] Load_Value;
  logic         Clear_Flag;
  logic [W-1:0] Counter_Out;
  logic         Terminal;
  logic         blow_up;
  logic         underflow;

  int m_cnt  = 0;
  int m_term = 0;
  int m_bu   = 0;
  int m_uf   = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  always #5 Clock = ~Clock;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .En         (En),
    .Up         (Up),
    .Load       (Load),
    .Load_Value (Load_Value),
    .Clear_Flag (Clear_Flag),
    .Counter_Out(Counter_Out),
    .Terminal   (Terminal),
    .blow_up    (blow_up),
    .underflow  (underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference behaviour from the counter's rules, using modular arithmetic on ints.
  task automatic model_edge(input bit rst, input bit en, input bit up, input bit ld,
                            input int lv, input bit clr);
    bit hit_top;
    bit hit_bot;
    hit_top = 0;
    hit_bot = 0;
    if (!rst) begin
      m_cnt = 0; m_term = 0; m_bu = 0; m_uf = 0;
      return;
    end
    if (ld) begin
      m_cnt = (lv > M - 1) ? M - 1 : lv;
    end else if (en && up) begin
      hit_top = (m_cnt == M - 1);
`ifdef COUNTER_SATURATE_EN
      if (!hit_top) m_cnt = m_cnt + 1;
`else
      m_cnt = (m_cnt + 1) % M;
`endif
    end else if (en && !up) begin
      hit_bot = (m_cnt == 0);
`ifdef COUNTER_SATURATE_EN
      if (!hit_bot) m_cnt = m_cnt - 1;
`else
      m_cnt = (m_cnt + M - 1) % M;
`endif
    end
    m_term = (hit_top || hit_bot) ? 1 : 0;
    m_bu   = (hit_top || (m_bu != 0 && !clr)) ? 1 : 0;
    m_uf   = (hit_bot || (m_uf != 0 && !clr)) ? 1 : 0;
  endtask

  task automatic step(input bit rst, input bit en, input bit up, input bit ld,
                      input logic [W-1:0] lv, input bit clr);
    @(negedge Clock);
    Reset = rst; En = en; Up = up; Load = ld; Load_Value = lv; Clear_Flag = clr;
    @(posedge Clock);
    model_edge(rst, en, up, ld, int'(lv), clr);
    #1;
    check_val("count",     32'(Counter_Out), 32'(m_cnt));
    check_val("terminal",  32'(Terminal),    32'(m_term));
    check_val("blow_up",   32'(blow_up),     32'(m_bu));
    check_val("underflow", 32'(underflow),   32'(m_uf));
  endtask

  initial begin
    Reset = 1'b0; En = 1'b0; Up = 1'b0; Load = 1'b0; Load_Value = '0; Clear_Flag = 1'b0;

    // reset, then count up through the wrap
    step(0, 0, 0, 0, 4'd0, 0);
    step(0, 1, 1, 1, 4'd7, 1);
    check_val("reset_count", 32'(Counter_Out), 32'd0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 4'd0, 0);
    check_val("after12_count", 32'(Counter_Out), 32'd2);

    // preload then count down through zero
    step(1, 0, 0, 1, 4'd3, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 4'd0, 0);
    check_val("down_count", 32'(Counter_Out), 32'd8);

    // clamped load, load beats enable
    step(1, 0, 0, 1, 4'd15, 0);
    check_val("clamp", 32'(Counter_Out), 32'd9);
    step(1, 1, 1, 1, 4'd2, 0);
    check_val("load_wins", 32'(Counter_Out), 32'd2);

    // set beats clear, then clear alone
    step(1, 0, 0, 1, 4'd9, 0);
    step(1, 1, 1, 0, 4'd0, 1);
    check_val("set_wins", 32'(blow_up), 32'd1);
    step(1, 0, 0, 0, 4'd0, 1);
    check_val("cleared", 32'(blow_up), 32'd0);

    // flags set, count at 6, reset while enabled
    step(1, 0, 0, 1, 4'd0, 0);
    step(1, 1, 0, 0, 4'd0, 0);
    step(1, 1, 1, 0, 4'd0, 0);
    step(1, 0, 0, 1, 4'd6, 0);
    step(0, 1, 1, 0, 4'd0, 0);
    step(1, 0, 0, 0, 4'd0, 0);

    // repeated attempts past the top bound
    step(1, 0, 0, 1, 4'd9, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 4'd0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
